store_size_rmw: RTL and testbench
=================================

STORE_SIZE_RMW -- requirements
Module: store_size_rmw

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, memory read latency in cycles (legal 1..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port store_size_control  input  2  00 SW, 01 SH, 10 SB, 11 treated as SB.
REQ-006 SHALL have port addr  input  32  byte address of store.
REQ-007 SHALL have port reg_data  input  32  register value to store (low bytes used for SH/SB).
REQ-008 SHALL have port mem_rdata  input  32  memory read data, valid READ_LAT cycles after address presented.
REQ-009 SHALL have port mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-010 SHALL have port mem_wdata  output  32  merged write word.
REQ-011 SHALL have port mem_we  output  1  write strobe, one cycle.
REQ-012 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port align_err  output  1  misalignment flag, pulses with done.

Function
REQ-015 SHALL implement states IDLE, RD_WAIT, WRITE, DONE.
REQ-016 SHALL capture store_size_control, addr, reg_data on the cycle start=1 in IDLE; later input changes have no effect until next IDLE.
REQ-017 SHALL ignore start while busy=1 (no queuing).
REQ-018 SW: IDLE -> WRITE -> DONE -> IDLE; mem_wdata = reg_data; no read; done two cycles after start.
REQ-019 SH/SB: IDLE -> RD_WAIT (exactly READ_LAT cycles, down-counter) -> WRITE -> DONE -> IDLE; done READ_LAT+2 cycles after start.
REQ-020 SHALL register mem_rdata at the end of the last RD_WAIT cycle.
REQ-021 SH merge: lane = addr[1]; halfword lane 0 = bits 15:0, lane 1 = bits 31:16; replaced with reg_data[15:0], other bits from read word.
REQ-022 SB merge: lane = addr[1:0]; byte lane n = bits 8n+7:8n replaced with reg_data[7:0], other bytes from read word.
REQ-023 mem_we SHALL be 1 only in WRITE, exactly one cycle per accepted request.
REQ-024 mem_addr SHALL hold the captured word address from RD_WAIT through WRITE; 0 in IDLE and DONE.
REQ-025 mem_wdata SHALL be 0 outside WRITE.
REQ-026 done SHALL be 1 only in DONE; new start accepted the cycle after DONE (IDLE).

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE from any state, including mid RD_WAIT or WRITE, cancelling the request.
REQ-028 After reset: mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, align_err=0, counter=0, captured registers=0.
REQ-029 reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 With STORE_ALIGN_CHECK_EN defined: SW with addr[1:0]!=0 or SH with addr[0]=1 SHALL go IDLE -> DONE directly, mem_we never asserted, align_err=1 with done.
REQ-031 Without STORE_ALIGN_CHECK_EN: align_err tied 0; misaligned SW writes full word to word address; SH uses addr[1] only.

Structure
REQ-032 Shared package store_pkg SHALL hold size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and state encodings.
REQ-033 Lane merge SHALL be a combinational sub-module store_merge (size, byte offset, reg_data, mem word -> merged word).

Verification
REQ-034 SW: addr=0x100, reg_data=0xDEADBEEF -> mem_we cycle 1 after start, mem_addr=0x100, mem_wdata=0xDEADBEEF, done cycle 2.
REQ-035 SB: addr=0x203, reg_data=0x000000AB, mem_rdata=0x11223344, READ_LAT=1 -> mem_wdata=0xAB223344, done cycle 3.
REQ-036 SH: addr=0x302, reg_data=0x0000CAFE, mem_rdata=0x11223344, READ_LAT=3 -> mem_wdata=0xCAFE3344, mem_we once, done cycle 5.
REQ-037 Reset asserted during RD_WAIT of SB -> next cycle IDLE, mem_we never asserted, all outputs 0.
REQ-038 start held high across SW request -> exactly one write; second request accepted only in cycle after done.
REQ-039 STORE_ALIGN_CHECK_EN: SH addr=0x101 -> done and align_err at cycle 1, mem_we=0 throughout.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the sub-word store read-modify-write engine.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WRITE   = 2'b10,
    DONE    = 2'b11
  } state_e;

  // Request captured on acceptance; raw size kept so 2'b11 survives as "byte".
  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

endpackage

// File: rtl/store_size_rmw_if.sv
// Request/memory bus of the store RMW engine; slave is the engine side.
interface store_size_rmw_if;
  logic        start;
  logic [1:0]  store_size_control;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        align_err;

  modport master (
    output start, store_size_control, addr, reg_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, align_err
  );

  modport slave (
    input  start, store_size_control, addr, reg_data, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, align_err
  );
endinterface

// File: rtl/store_merge.sv
// Combinational lane merge: drops the store bytes into the word read from memory.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_word,
  output logic [31:0] merged
);

  always_comb begin
    merged = mem_word;
    case (size)
      SZ_WORD: merged = reg_data;
      SZ_HALF: begin
        if (off[1]) merged[31:16] = reg_data[15:0];
        else        merged[15:0]  = reg_data[15:0];
      end
      // 2'b11 falls through to byte behaviour
      default: merged[{off, 3'b000} +: 8] = reg_data[7:0];
    endcase
  end

endmodule

// File: rtl/store_size_rmw.sv
// Store engine: SW writes directly, SH/SB read the word, merge, and write back.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned SW/SH with align_err.
module store_size_rmw
  import store_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  store_size_rmw_if.slave bus
);

  state_e      state, state_nxt;
  req_t        req_q;
  logic [2:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] merged;
  logic        misalign;
  logic        accept;

  assign accept = (state == IDLE) && bus.start;

`ifdef STORE_ALIGN_CHECK_EN
  logic err_q;

  assign misalign = ((bus.store_size_control == SZ_WORD) && (bus.addr[1:0] != 2'b00)) ||
                    ((bus.store_size_control == SZ_HALF) && bus.addr[0]);

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end

  assign bus.align_err = (state == DONE) && err_q;
`else
  assign misalign      = 1'b0;
  assign bus.align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= '{size: bus.store_size_control, addr: bus.addr, data: bus.reg_data};
        cnt_q <= 3'(READ_LAT - 1);
      end
      // Read word is taken at the end of the last wait cycle only
      if (state == RD_WAIT) begin
        if (cnt_q == 3'd0) rdata_q <= bus.mem_rdata;
        else               cnt_q   <= cnt_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (misalign)                                state_nxt = DONE;
          else if (bus.store_size_control == SZ_WORD) state_nxt = WRITE;
          else                                         state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt_q == 3'd0) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  store_merge u_merge (
    .size     (req_q.size),
    .off      (req_q.addr[1:0]),
    .reg_data (req_q.data),
    .mem_word (rdata_q),
    .merged   (merged)
  );

  assign bus.mem_addr  = ((state == RD_WAIT) || (state == WRITE)) ? {req_q.addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata = (state == WRITE) ? merged : 32'd0;
  assign bus.mem_we    = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_store_size_rmw.sv
// Directed vector bench for store_size_rmw, with READ_LAT=1 and READ_LAT=3 instances.
module tb_store_size_rmw;

  localparam logic [31:0] GARB = 32'hA5A5_A5A5;

  typedef struct {
    logic        lat3;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          nwe;
    logic [31:0] wdata;
    logic [31:0] maddr;
    int          wecyc;
    int          donecyc;
    logic        aerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3, sel3;
  logic [1:0]  sz;
  logic [31:0] addr, data, rdata;
  int          nvec = 0;
  int          nerr = 0;
  vec_t        vecs[11];

  store_size_rmw_if if1 ();
  store_size_rmw_if if3 ();

  assign if1.start = start1;
  assign if3.start = start3;
  assign if1.store_size_control = sz;
  assign if3.store_size_control = sz;
  assign if1.addr = addr;
  assign if3.addr = addr;
  assign if1.reg_data = data;
  assign if3.reg_data = data;
  assign if1.mem_rdata = rdata;
  assign if3.mem_rdata = rdata;

  store_size_rmw #(.READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  store_size_rmw #(.READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  always #5 clk = ~clk;

  wire [31:0] o_maddr = sel3 ? if3.mem_addr  : if1.mem_addr;
  wire [31:0] o_wdata = sel3 ? if3.mem_wdata : if1.mem_wdata;
  wire        o_we    = sel3 ? if3.mem_we    : if1.mem_we;
  wire        o_busy  = sel3 ? if3.busy      : if1.busy;
  wire        o_done  = sel3 ? if3.done      : if1.done;
  wire        o_aerr  = sel3 ? if3.align_err : if1.align_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nwe, wecyc, donecyc, lat;
    logic [31:0] wd, wa, dn_addr, dn_wdata;
    logic aerr, b1;
    nwe = 0; wecyc = -1; donecyc = -1; wd = 0; wa = 0; aerr = 0; b1 = 0;
    dn_addr = 0; dn_wdata = 0;
    lat = v.lat3 ? 3 : 1;
    sel3 = v.lat3;
    @(negedge clk);
    sz = v.sz; addr = v.addr; data = v.data; rdata = GARB;
    if (v.lat3) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 1; k <= 12 && donecyc < 0; k++) begin
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      // captured request must ignore later input changes
      sz = ~v.sz; addr = ~v.addr; data = ~v.data;
      rdata = (k == lat) ? v.rdata : GARB;
      if (k == 1) b1 = o_busy;
      if (o_we) begin nwe++; wecyc = k; wd = o_wdata; wa = o_maddr; end
      if (o_done) begin
        donecyc = k; aerr = o_aerr; dn_addr = o_maddr; dn_wdata = o_wdata;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d busy_c1", idx), {31'd0, b1}, 32'd1);
    chk($sformatf("v%0d we_count", idx), nwe, v.nwe);
    chk($sformatf("v%0d done_cycle", idx), donecyc, v.donecyc);
    chk($sformatf("v%0d align_err", idx), {31'd0, aerr}, {31'd0, v.aerr});
    chk($sformatf("v%0d done_addr_wdata", idx), dn_addr | dn_wdata, 32'd0);
    chk($sformatf("v%0d idle_busy", idx), {31'd0, o_busy}, 32'd0);
    if (v.nwe != 0) begin
      chk($sformatf("v%0d we_cycle", idx), wecyc, v.wecyc);
      chk($sformatf("v%0d wdata", idx), wd, v.wdata);
      chk($sformatf("v%0d maddr", idx), wa, v.maddr);
    end
  endtask

  initial begin
    logic [4:0] wep, dnp, busyp;
    int nwe, ndone;

    vecs[0] = '{1'b0, 2'b00, 32'h100, 32'hDEADBEEF, GARB,          1, 32'hDEADBEEF, 32'h100, 1, 2, 1'b0};
    vecs[1] = '{1'b0, 2'b10, 32'h203, 32'h000000AB, 32'h11223344, 1, 32'hAB223344, 32'h200, 2, 3, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 32'h302, 32'h0000CAFE, 32'h11223344, 1, 32'hCAFE3344, 32'h300, 4, 5, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 32'h200, 32'hFFFFFF55, 32'h11223344, 1, 32'h11223355, 32'h200, 4, 5, 1'b0};
    vecs[4] = '{1'b0, 2'b10, 32'h201, 32'h00000066, 32'h11223344, 1, 32'h11226644, 32'h200, 2, 3, 1'b0};
    vecs[5] = '{1'b0, 2'b01, 32'h300, 32'h1234BEEF, 32'h11223344, 1, 32'h1122BEEF, 32'h300, 2, 3, 1'b0};
    vecs[6] = '{1'b0, 2'b11, 32'h202, 32'h00000077, 32'h11223344, 1, 32'h11773344, 32'h200, 2, 3, 1'b0};
    vecs[7] = '{1'b1, 2'b00, 32'h404, 32'hCAFEF00D, GARB,          1, 32'hCAFEF00D, 32'h404, 1, 2, 1'b0};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[8] = '{1'b0, 2'b01, 32'h101, 32'h0000BEEF, 32'h11223344, 0, 32'h0, 32'h0, 0, 1, 1'b1};
    vecs[9] = '{1'b0, 2'b00, 32'h103, 32'h01020304, GARB,          0, 32'h0, 32'h0, 0, 1, 1'b1};
`else
    vecs[8] = '{1'b0, 2'b01, 32'h101, 32'h0000BEEF, 32'h11223344, 1, 32'h1122BEEF, 32'h100, 2, 3, 1'b0};
    vecs[9] = '{1'b0, 2'b00, 32'h103, 32'h01020304, GARB,          1, 32'h01020304, 32'h100, 1, 2, 1'b0};
`endif
    vecs[10] = '{1'b1, 2'b10, 32'h103, 32'h000000C3, 32'h11223344, 1, 32'hC3223344, 32'h100, 4, 5, 1'b0};

    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
    sz = 2'b00; addr = 32'd0; data = 32'd0; rdata = GARB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_outs1", {28'd0, if1.busy, if1.done, if1.mem_we, if1.align_err}, 32'd0);
    chk("reset_outs3", {28'd0, if3.busy, if3.done, if3.mem_we, if3.align_err}, 32'd0);
    chk("reset_bus", if1.mem_addr | if1.mem_wdata | if3.mem_addr | if3.mem_wdata, 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the middle of an SB read wait cancels the request
    sel3 = 1'b1;
    @(negedge clk);
    sz = 2'b10; addr = 32'h203; data = 32'hAB; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("rst_mid busy_rdwait", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid flags", {28'd0, o_busy, o_done, o_we, o_aerr}, 32'd0);
    chk("rst_mid bus", o_maddr | o_wdata, 32'd0);
    nwe = 0; ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_we) nwe++;
      if (o_done) ndone++;
    end
    chk("rst_mid no_write", nwe + ndone, 0);

    // Reset wins over start in the same cycle
    @(negedge clk);
    reset = 1'b1; start3 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start3 = 1'b0;
    chk("rst_prio busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("rst_prio still_idle", {31'd0, o_busy}, 32'd0);

    // start held high: second SW accepted only in the IDLE cycle after done
    sel3 = 1'b0;
    @(negedge clk);
    sz = 2'b00; addr = 32'h500; data = 32'h11111111; start1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      wep[k-1] = o_we; dnp[k-1] = o_done; busyp[k-1] = o_busy;
    end
    start1 = 1'b0;
    chk("hold we_pattern", {27'd0, wep}, 32'b01001);
    chk("hold done_pattern", {27'd0, dnp}, 32'b10010);
    chk("hold busy_pattern", {27'd0, busyp}, 32'b11011);
    @(negedge clk);
    chk("hold final_idle", {31'd0, o_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
